serial_deser: RTL and testbench
===============================

SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 Parameter WIDTH, default 8; number of data bits assembled per word; legal range 2..32.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start_i  input  1  arm strobe; clears partial word and bit counter, enters SHIFT.
REQ-005 enable_i  input  1  bit strobe; data_i is sampled on a rising edge where enable_i=1.
REQ-006 data_i  input  1  serial bit stream, LSB first.
REQ-007 ack_i  input  1  consumer acknowledge of the held word.
REQ-008 data_o  output  WIDTH  assembled word; first received bit at data_o[0].
REQ-009 valid_o  output  1  data_o holds a complete word awaiting ack_i.
REQ-010 busy_o  output  1  high while in SHIFT (or PARITY).
REQ-011 overrun_o  output  1  sticky flag; a bit strobe arrived while a word was held.
REQ-012 parity_err_o  output  1  parity mismatch on the held word (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, PARITY (only when the macro is defined), and HOLD.
REQ-014 IDLE: enable_i ignored; start_i=1 -> SHIFT, bit counter=0, shift register=0.
REQ-015 SHIFT: each enable_i=1 edge SHALL shift: reg <= {data_i, reg[WIDTH-1:1]}, counter+1.
REQ-016 On the edge sampling bit WIDTH, SHALL load data_o from the updated shift value, set valid_o, and enter HOLD (or PARITY); valid_o is visible in the cycle after that edge.
REQ-017 Cycles with enable_i=0 in SHIFT SHALL leave the register and counter unchanged (gaps allowed, no timeout).
REQ-018 start_i in SHIFT SHALL discard the partial word and restart at counter=0; a concurrent enable_i bit is discarded.
REQ-019 start_i and enable_i together in IDLE: start wins; the bit is not sampled.
REQ-020 HOLD: data_o and valid_o stable until ack_i=1; ack_i -> IDLE, valid_o cleared next edge.
REQ-021 HOLD with ack_i=1 and start_i=1 together SHALL go directly to SHIFT with counter cleared.
REQ-022 enable_i=1 in HOLD SHALL set overrun_o and discard the bit; start_i alone in HOLD is ignored.
REQ-023 overrun_o SHALL clear only on an accepted start_i or reset.
REQ-024 ack_i outside HOLD SHALL have no effect.
REQ-025 busy_o SHALL equal (state==SHIFT or state==PARITY), registered.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, counter 0, shift register 0, data_o 0, valid_o 0, busy_o 0, overrun_o 0, parity_err_o 0.
REQ-027 Reset mid-word or mid-HOLD SHALL discard all data; no word is delivered after release until a new start_i.

Configuration
REQ-028 Macro SERIAL_DESER_PARITY_EN defined: after bit WIDTH the FSM SHALL enter PARITY; valid_o is deferred until the next enable_i edge, which samples an even-parity bit; parity_err_o = XOR(data bits, parity bit), registered with valid_o, cleared on ack_i.
REQ-029 Macro undefined: no PARITY state, valid_o per REQ-016, parity_err_o tied 0.

Verification
REQ-030 WIDTH=8: start_i, then bits 1,0,1,1,0,0,1,0 on consecutive enable_i edges -> data_o=8'h4D, valid_o=1 one cycle after 8th edge, busy_o=0.
REQ-031 Same stream with 3 idle cycles between bits 4 and 5 -> identical data_o=8'h4D, no early valid_o.
REQ-032 After 5 bits assert start_i, then send 8'hA5 LSB first -> data_o=8'hA5 only; partial bits absent.
REQ-033 In HOLD with 8'h3C, pulse enable_i twice -> data_o stays 8'h3C, overrun_o=1; ack_i+start_i same cycle -> SHIFT, overrun_o=0.
REQ-034 rst_n low after 4 bits -> all outputs 0 asynchronously; after release, enable_i without start_i -> valid_o stays 0.
REQ-035 SERIAL_DESER_PARITY_EN: 8'h4D then parity 0 -> parity_err_o=0; 8'h4D then parity 1 -> parity_err_o=1, valid_o=1 in both cases.

Source files
------------

// File: rtl/serial_deser_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_deser_if : control, serial data and word handshake bundle   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface serial_deser_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             enable_i;
  logic             data_i;
  logic             ack_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             busy_o;
  logic             overrun_o;
  logic             parity_err_o;

  modport master (
    output start_i, enable_i, data_i, ack_i,
    input  data_o, valid_o, busy_o, overrun_o, parity_err_o
  );

  modport slave (
    input  start_i, enable_i, data_i, ack_i,
    output data_o, valid_o, busy_o, overrun_o, parity_err_o
  );
endinterface
`default_nettype wire

// File: rtl/serial_deser.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_deser : LSB-first serial-to-parallel word assembler with a  |
// | held-word handshake. Optional even parity: SERIAL_DESER_PARITY_EN. |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module serial_deser #(
  parameter int WIDTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_n,
  serial_deser_if.slave bus
);
  localparam int       c_cw    = $clog2(WIDTH);
  localparam [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

  localparam [1:0] c_idle   = 2'd0;
  localparam [1:0] c_shift  = 2'd1;
  localparam [1:0] c_hold   = 2'd3;
`ifdef SERIAL_DESER_PARITY_EN
  localparam [1:0] c_parity = 2'd2;
  localparam [1:0] c_after_data = c_parity;
`else
  localparam [1:0] c_after_data = c_hold;
`endif

  logic [1:0]       r_state, w_state_next;
  logic [c_cw-1:0]  r_cnt;
  logic [WIDTH-1:0] r_shift, w_shift_upd;
  logic [WIDTH-1:0] r_data;
  logic             r_valid, r_busy, r_overrun;
  logic             w_accept_start, w_shift_en, w_last, w_ack, w_overrun_set;
`ifdef SERIAL_DESER_PARITY_EN
  logic             r_parity_err, w_par_en;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (bus.start_i) w_state_next = c_shift;
      c_shift: begin
        if (bus.start_i)                               w_state_next = c_shift;
        else if (bus.enable_i && (r_cnt == c_last))    w_state_next = c_after_data;
      end
`ifdef SERIAL_DESER_PARITY_EN
      c_parity: begin
        if (bus.start_i)       w_state_next = c_shift;
        else if (bus.enable_i) w_state_next = c_hold;
      end
`endif
      c_hold:  if (bus.ack_i) w_state_next = bus.start_i ? c_shift : c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  always_comb begin
    w_accept_start = 1'b0;
    w_shift_en     = 1'b0;
    w_last         = 1'b0;
    w_ack          = 1'b0;
    w_overrun_set  = 1'b0;
    w_shift_upd    = {bus.data_i, r_shift[WIDTH-1:1]};
`ifdef SERIAL_DESER_PARITY_EN
    w_par_en       = 1'b0;
`endif
    case (r_state)
      c_idle:  w_accept_start = bus.start_i;
      c_shift: begin
        w_accept_start = bus.start_i;
        w_shift_en     = bus.enable_i && !bus.start_i;
        w_last         = w_shift_en && (r_cnt == c_last);
      end
`ifdef SERIAL_DESER_PARITY_EN
      c_parity: begin
        w_accept_start = bus.start_i;
        w_par_en       = bus.enable_i && !bus.start_i;
      end
`endif
      c_hold: begin
        w_ack          = bus.ack_i;
        w_accept_start = bus.ack_i && bus.start_i;
        w_overrun_set  = bus.enable_i;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs; ack has the last word on valid.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
`ifdef SERIAL_DESER_PARITY_EN
      r_busy <= (w_state_next == c_shift) || (w_state_next == c_parity);
`else
      r_busy <= (w_state_next == c_shift);
`endif
      if (w_accept_start) begin
        r_cnt     <= '0;
        r_shift   <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_shift_en) begin
          r_shift <= w_shift_upd;
          r_cnt   <= r_cnt + c_cw'(1);
        end
        if (w_overrun_set) r_overrun <= 1'b1;
      end
      if (w_last) begin
        r_data <= w_shift_upd;
`ifndef SERIAL_DESER_PARITY_EN
        r_valid <= 1'b1;
`endif
      end
`ifdef SERIAL_DESER_PARITY_EN
      if (w_par_en) begin
        r_valid      <= 1'b1;
        r_parity_err <= (^r_data) ^ bus.data_i;
      end
      if (w_ack) r_parity_err <= 1'b0;
`endif
      if (w_ack) r_valid <= 1'b0;
    end
  end

  assign bus.data_o    = r_data;
  assign bus.valid_o   = r_valid;
  assign bus.busy_o    = r_busy;
  assign bus.overrun_o = r_overrun;
`ifdef SERIAL_DESER_PARITY_EN
  assign bus.parity_err_o = r_parity_err;
`else
  assign bus.parity_err_o = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_serial_deser.sv
`default_nettype none
// Scoreboard bench for serial_deser (WIDTH=8): directed words are queued on
// issue and popped by a monitor on every rising valid_o.
module tb_serial_deser;
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [8:0] sb[$];
  logic prev_valid = 1'b0;

  serial_deser_if #(.WIDTH(8)) bus_if ();
  serial_deser #(.WIDTH(8)) dut (.clk_i(clk_i), .rst_n(rst_n), .bus(bus_if));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare the held word at the moment valid_o rises.
  always @(negedge clk_i) begin
    if (bus_if.valid_o && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'd0, bus_if.valid_o}, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("sb_data", {24'd0, bus_if.data_o}, {24'd0, e[7:0]});
        chk("sb_parity_err", {31'd0, bus_if.parity_err_o}, {31'd0, e[8]});
      end
    end
    prev_valid = bus_if.valid_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus_if.enable_i = 1'b1;
    bus_if.data_i   = b;
    tick();
    bus_if.enable_i = 1'b0;
    bus_if.data_i   = 1'b0;
  endtask

  task automatic pulse_start(input logic with_en);
    bus_if.start_i  = 1'b1;
    bus_if.enable_i = with_en;
    bus_if.data_i   = with_en;
    tick();
    bus_if.start_i  = 1'b0;
    bus_if.enable_i = 1'b0;
    bus_if.data_i   = 1'b0;
  endtask

  task automatic do_ack();
    bus_if.ack_i = 1'b1;
    tick();
    bus_if.ack_i = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap_at, input logic bad_par);
    logic perr;
    perr = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
    perr = bad_par;
`endif
    sb.push_back({perr, w});
    for (int i = 0; i < 8; i++) begin
      chk("no_early_valid", {31'd0, bus_if.valid_o}, 32'd0);
      send_bit(w[i]);
      if (i == gap_at) begin
        repeat (3) tick();
      end
    end
`ifdef SERIAL_DESER_PARITY_EN
    chk("valid_deferred", {31'd0, bus_if.valid_o}, 32'd0);
    send_bit((^w) ^ bad_par);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, {24'd0, bus_if.data_o}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus_if.valid_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus_if.busy_o}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, bus_if.overrun_o}, 32'd0);
    chk({tag, "_perr"}, {31'd0, bus_if.parity_err_o}, 32'd0);
  endtask

  initial begin
    bus_if.start_i = 1'b0; bus_if.enable_i = 1'b0;
    bus_if.data_i  = 1'b0; bus_if.ack_i    = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic word 0x4D, then ack clears valid.
    pulse_start(1'b0);
    chk("busy_after_start", {31'd0, bus_if.busy_o}, 32'd1);
    send_word(8'h4D, -1, 1'b0);
    chk("valid_after_word", {31'd0, bus_if.valid_o}, 32'd1);
    chk("busy_in_hold", {31'd0, bus_if.busy_o}, 32'd0);
    do_ack();
    chk("valid_after_ack", {31'd0, bus_if.valid_o}, 32'd0);

    // Same word with a 3-cycle gap after the 4th bit.
    pulse_start(1'b0);
    send_word(8'h4D, 3, 1'b0);
    chk("gap_valid", {31'd0, bus_if.valid_o}, 32'd1);
    chk("gap_data", {24'd0, bus_if.data_o}, 32'h4D);
    do_ack();

    // Start+enable in IDLE, 5 partial bits, restart with a concurrent bit, then 0xA5.
    pulse_start(1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    pulse_start(1'b1);
    send_word(8'hA5, -1, 1'b0);
    chk("restart_data", {24'd0, bus_if.data_o}, 32'hA5);
    do_ack();

    // Overrun in HOLD, start alone ignored, ack+start restarts.
    pulse_start(1'b0);
    send_word(8'h3C, -1, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("hold_data", {24'd0, bus_if.data_o}, 32'h3C);
    chk("overrun_set", {31'd0, bus_if.overrun_o}, 32'd1);
    pulse_start(1'b0);
    chk("start_ignored_valid", {31'd0, bus_if.valid_o}, 32'd1);
    chk("start_ignored_ovr", {31'd0, bus_if.overrun_o}, 32'd1);
    bus_if.ack_i = 1'b1;
    pulse_start(1'b0);
    bus_if.ack_i = 1'b0;
    chk("ackstart_busy", {31'd0, bus_if.busy_o}, 32'd1);
    chk("ackstart_overrun", {31'd0, bus_if.overrun_o}, 32'd0);
    chk("ackstart_valid", {31'd0, bus_if.valid_o}, 32'd0);
    send_word(8'h81, -1, 1'b0);
    do_ack();

`ifdef SERIAL_DESER_PARITY_EN
    pulse_start(1'b0);
    send_word(8'h4D, -1, 1'b1);
    chk("bad_par_valid", {31'd0, bus_if.valid_o}, 32'd1);
    do_ack();
    chk("perr_cleared", {31'd0, bus_if.parity_err_o}, 32'd0);
`endif

    // Asynchronous reset mid-word.
    pulse_start(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #2;
    chk_all_zero("rst_midword");
    tick();
    rst_n = 1'b1;
    // Asynchronous reset mid-HOLD with overrun set.
    pulse_start(1'b0);
    send_word(8'hF0, -1, 1'b0);
    send_bit(1'b1);
    chk("pre_rst_overrun", {31'd0, bus_if.overrun_o}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk_all_zero("rst_hold");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    repeat (2) tick();
    chk("no_word_after_rst", {31'd0, bus_if.valid_o}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
